// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO status block.
// Optional high-water mark tracking is enabled with the FIFO_PEAK_EN macro.
package fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF:0] ptr_t;
  typedef logic [ADDR_W_DEF:0] lvl_t;

endpackage

// File: rtl/fifo_level_calc.sv
// Combinational next-pointer and next-level computation for fifo_status.
// Accepts mirror the external counters: advance only when req=1 and the gating flag=0.
module fifo_level_calc
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W:0] wr_ptr,
  input  logic [ADDR_W:0] rd_ptr,
  input  logic            wr_req,
  input  logic            rd_req,
  input  logic            full,
  input  logic            empty,
  output logic            wr_acc,
  output logic            rd_acc,
  output logic [ADDR_W:0] nxt_wr,
  output logic [ADDR_W:0] nxt_rd,
  output logic [ADDR_W:0] nxt_lvl
);

  always_comb begin
    wr_acc  = wr_req & ~full;
    rd_acc  = rd_req & ~empty;
    // Modulo 2**(ADDR_W+1) arithmetic makes pointer wrap transparent to the level.
    nxt_wr  = wr_ptr + {{ADDR_W{1'b0}}, wr_acc};
    nxt_rd  = rd_ptr + {{ADDR_W{1'b0}}, rd_acc};
    nxt_lvl = nxt_wr - nxt_rd;
  end

endmodule

// File: rtl/fifo_status.sv
// Registered FIFO status flags, occupancy, sticky error flags and optional peak level.
// Define FIFO_PEAK_EN to enable the high-water mark register; otherwise peak is tied to 0.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [ADDR_W:0] wr_ptr,
  input  logic [ADDR_W:0] rd_ptr,
  input  logic            wr_req,
  input  logic            rd_req,
  input  logic            clr_err,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            underflow,
  output logic [ADDR_W:0] peak
);

  // Handshake: wr_req/rd_req are valids; ~full/~empty are the matching readys.
  // A transfer happens on a rising edge where valid=1 and ready=1.

  localparam logic [ADDR_W:0] AF_L = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_L = AE_THRESH[ADDR_W:0];

  logic            wr_acc;
  logic            rd_acc;
  logic [ADDR_W:0] nxt_wr;
  logic [ADDR_W:0] nxt_rd;
  logic [ADDR_W:0] nxt_lvl;
  logic            nxt_full;
  logic            nxt_empty;
  logic            ov_set;
  logic            un_set;

  fifo_level_calc #(.ADDR_W(ADDR_W)) u_calc (
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .full    (full),
    .empty   (empty),
    .wr_acc  (wr_acc),
    .rd_acc  (rd_acc),
    .nxt_wr  (nxt_wr),
    .nxt_rd  (nxt_rd),
    .nxt_lvl (nxt_lvl)
  );

  always_comb begin
    nxt_full  = (nxt_wr[ADDR_W] != nxt_rd[ADDR_W]) &&
                (nxt_wr[ADDR_W-1:0] == nxt_rd[ADDR_W-1:0]);
    nxt_empty = (nxt_wr == nxt_rd);
    ov_set    = wr_req & full;
    un_set    = rd_req & empty;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      level        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      full         <= nxt_full;
      empty        <= nxt_empty;
      almost_full  <= (nxt_lvl >= AF_L);
      almost_empty <= (nxt_lvl <= AE_L);
      level        <= nxt_lvl;
      // A new error in the same cycle as clr_err wins over the clear.
      overflow     <= ov_set | (overflow & ~clr_err);
      underflow    <= un_set | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_PEAK_EN
  logic [ADDR_W:0] peak_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      peak_q <= '0;
    end else if (clr_err) begin
      peak_q <= nxt_lvl;
    end else if (nxt_lvl > peak_q) begin
      peak_q <= nxt_lvl;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_fifo_status.sv
// Directed testbench for fifo_status with ADDR_W=3, AF_THRESH=6, AE_THRESH=2.
module tb_fifo_status;
  import fifo_pkg::*;

  logic clk;
  logic n_rst;
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic wr_req;
  logic rd_req;
  logic clr_err;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  lvl_t level;
  logic overflow;
  logic underflow;
  lvl_t peak;

  int n_checks;
  int n_errors;

  fifo_status #(.ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .peak         (peak)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int lvl, input logic f, input logic e,
                           input logic af, input logic ae, input logic ov, input logic un);
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  // driver: one clock cycle; models the external pointer counters
  task automatic cyc(input logic w, input logic r, input logic c);
    ptr_t d;
    logic m_full;
    logic m_empty;
    wr_req  = w;
    rd_req  = r;
    clr_err = c;
    d       = wr_ptr - rd_ptr;
    m_full  = (d == ptr_t'(DEPTH_DEF));
    m_empty = (d == '0);
    @(posedge clk);
    #1;
    if (!n_rst) begin
      wr_ptr = '0;
      rd_ptr = '0;
    end else begin
      if (w && !m_full)  wr_ptr = wr_ptr + 1'b1;
      if (r && !m_empty) rd_ptr = rd_ptr + 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic int exp_peak(input int p);
`ifdef FIFO_PEAK_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    wr_ptr   = '0;
    rd_ptr   = '0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);

    // reset with active-looking inputs
    repeat (2) begin
      wr_ptr = 4'd5;
      wr_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    wr_ptr = '0;
    rd_ptr = '0;
    wr_req = 1'b0;
    chk_state("reset", 0, 0, 1, 0, 1, 0, 0);
    check("reset.peak", 32'(peak), 0);
    n_rst = 1'b1;

    // peak: fill to 5, drain to 0, then clear
    repeat (5) cyc(1, 0, 0);
    chk_state("fill5", 5, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0);
    chk_state("drain0", 0, 0, 1, 0, 1, 0, 0);
    check("peak.after_drain", 32'(peak), 32'(exp_peak(5)));
    cyc(0, 0, 1);
    check("peak.after_clr", 32'(peak), 0);

    // fill 8 from empty
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0);
      chk_state($sformatf("fill%0d", i), i, (i == 8), 0, (i >= 6), (i <= 2), 0, 0);
    end
    cyc(1, 0, 0);
    chk_state("overfill", 8, 1, 0, 1, 0, 1, 0);

    // set wins over clear, then clear alone
    cyc(1, 0, 1);
    check("clrprio.set_wins", 32'(overflow), 1);
    cyc(0, 0, 1);
    chk_state("clrprio.cleared", 8, 1, 0, 1, 0, 0, 0);

    // full collision: only the read is accepted
    cyc(1, 1, 0);
    chk_state("full_both", 7, 0, 0, 1, 0, 1, 0);
    cyc(1, 1, 0);
    chk_state("mid_both", 7, 0, 0, 1, 0, 1, 0);

    // wrap vector: wr=1011, rd=0011 is full
    wr_ptr = 4'b1011;
    rd_ptr = 4'b0011;
    cyc(0, 0, 1);
    chk_state("wrap.setup", 8, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0);
    chk_state("wrap.both", 7, 0, 0, 1, 0, 1, 0);

    // write pointer rolls over 1111 -> 0000
    wr_ptr = 4'b1111;
    rd_ptr = 4'b1000;
    cyc(0, 0, 1);
    chk_state("roll.setup", 7, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0);
    chk_state("roll.write", 8, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0);
    chk_state("roll.read", 7, 0, 0, 1, 0, 0, 0);

    // empty collision: only the write is accepted
    wr_ptr = 4'b1110;
    rd_ptr = 4'b1110;
    cyc(0, 0, 1);
    chk_state("empty.setup", 0, 0, 1, 0, 1, 0, 0);
    cyc(1, 1, 0);
    chk_state("empty_both", 1, 0, 0, 0, 1, 0, 1);

    // reset mid-operation
    repeat (2) cyc(1, 0, 0);
    check("pre_rst.level", 32'(level), 3);
    n_rst = 1'b0;
    cyc(1, 1, 0);
    chk_state("mid_rst", 0, 0, 1, 0, 1, 0, 0);
    check("mid_rst.peak", 32'(peak), 0);
    n_rst = 1'b1;
    cyc(1, 0, 0);
    chk_state("post_rst", 1, 0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
